// File: rtl/abr_params_pkg.sv
// Shared widths, FSM state type and Power2Round per-coefficient arithmetic.
package abr_params_pkg;

  localparam int unsigned CoeffBits = 23;

  function automatic int unsigned t1_w(input int unsigned d);
    return CoeffBits - d;
  endfunction

  localparam int unsigned T1_W = t1_w(13);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} p2r_state_e;

  // r1 = (r + 2^(d-1) - 1) >> d
  function automatic logic [22:0] p2r_t1(input logic [22:0] r, input int unsigned d);
    logic [23:0] sum;
    sum = {1'b0, r} + 24'((1 << (d - 1)) - 1);
    return 23'(sum >> d);
  endfunction

  // t0 = 2^(d-1) - (r - r1 * 2^d); modular 24-bit arithmetic, result lies in [0, 2^d)
  function automatic logic [22:0] p2r_t0(input logic [22:0] r, input int unsigned d);
    logic [23:0] r1s;
    r1s = {1'b0, p2r_t1(r, d)} << d;
    return 23'(24'(1 << (d - 1)) - ({1'b0, r} - r1s));
  endfunction

endpackage

// File: rtl/abr_bit_packer.sv
// Generic LSB-first bit accumulator: takes IN_W-bit groups, emits OUT_W-bit words.
module abr_bit_packer #(
  parameter int unsigned IN_W  = 104,
  parameter int unsigned OUT_W = 64
) (
  input  logic                             clk,
  input  logic                             clear,
  input  logic                             push_valid,
  output logic                             push_ready,
  input  logic [IN_W-1:0]                  push_data,
  output logic                             pop_valid,
  input  logic                             pop_ready,
  output logic [OUT_W-1:0]                 pop_data,
  output logic [$clog2(IN_W+OUT_W+1)-1:0]  fill
);

  localparam int unsigned AccW  = IN_W + OUT_W;
  localparam int unsigned FillW = $clog2(IN_W + OUT_W + 1);

  logic [AccW-1:0]  acc_q, acc_d;
  logic [FillW-1:0] fill_q, fill_d;

  assign push_ready = fill_q < FillW'(OUT_W);
  assign pop_valid  = fill_q >= FillW'(OUT_W);
  assign pop_data   = acc_q[OUT_W-1:0];
  assign fill       = fill_q;

  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    if (pop_valid && pop_ready) begin
      acc_d  = acc_q >> OUT_W;
      fill_d = fill_q - FillW'(OUT_W);
    end
    // Bits above fill are always zero, so a new group can simply be OR-ed in.
    if (push_valid && push_ready) begin
      acc_d  = acc_d | (AccW'(push_data) << fill_d);
      fill_d = fill_d + FillW'(IN_W);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/power2round_stream.sv
// Streaming Power2Round: splits t coefficients into t1 lanes and a packed t0 word stream.
module power2round_stream
  import abr_params_pkg::*;
#(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned COEFF_W   = 24,
  parameter int unsigned MLDSA_Q   = 8380417,
  parameter int unsigned MLDSA_D   = 13,
  parameter int unsigned MLDSA_N   = 256,
  parameter int unsigned MAX_POLY  = 8,
  parameter int unsigned T0_OUT_W  = 64
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             zeroize,
  input  logic                                             start,
  input  logic [$clog2(MAX_POLY+1)-1:0]                    num_poly,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [NUM_LANES*COEFF_W-1:0]                     in_data,
  output logic                                             t1_valid,
  input  logic                                             t1_ready,
  output logic [NUM_LANES*(23-MLDSA_D)-1:0]                t1_data,
  output logic [$clog2(MAX_POLY*MLDSA_N/NUM_LANES)-1:0]    t1_idx,
  output logic                                             t0_valid,
  input  logic                                             t0_ready,
  output logic [T0_OUT_W-1:0]                              t0_data,
  output logic                                             busy,
  output logic                                             range_err,
  output logic                                             done
);

  localparam int unsigned T1W    = t1_w(MLDSA_D);
  localparam int unsigned GrpW   = NUM_LANES * MLDSA_D;
  localparam int unsigned Bpp    = MLDSA_N / NUM_LANES;
  localparam int unsigned IdxW   = $clog2(MAX_POLY * MLDSA_N / NUM_LANES);
  localparam int unsigned BcntW  = $clog2(MAX_POLY * Bpp + 1);
  localparam int unsigned FillW  = $clog2(GrpW + T0_OUT_W + 1);

  if (((MLDSA_N * MLDSA_D) % T0_OUT_W) != 0 || (MLDSA_N % NUM_LANES) != 0) begin : g_bad_cfg
    $error("power2round_stream: unsupported parameter combination");
  end

  p2r_state_e state_q, state_d;
  logic                   clear, start_ok, in_fire, s1_fire, pk_push, pk_room;
  logic                   s1_valid_q;
  logic [NUM_LANES*T1W-1:0] s1_t1_q, beat_t1;
  logic [GrpW-1:0]        s1_t0_q, beat_t0;
  logic [NUM_LANES-1:0]   lane_oor;
  logic [BcntW-1:0]       beat_cnt_q, total_beats_q;
  logic [IdxW-1:0]        t1_idx_q;
  logic                   range_err_q;
  logic [FillW-1:0]       pk_fill;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [COEFF_W-1:0] coeff;
    assign coeff = in_data[i*COEFF_W +: COEFF_W];
    assign beat_t1[i*T1W +: T1W]         = T1W'(p2r_t1(coeff[22:0], MLDSA_D));
    assign beat_t0[i*MLDSA_D +: MLDSA_D] = MLDSA_D'(p2r_t0(coeff[22:0], MLDSA_D));
    assign lane_oor[i]                   = coeff >= COEFF_W'(MLDSA_Q);
  end

  assign clear    = reset | zeroize;
  assign start_ok = start && (state_q == StIdle);
  assign in_ready = (state_q == StRun) && (!s1_valid_q || s1_fire);
  assign in_fire  = in_valid && in_ready;
  assign t1_valid = s1_valid_q && pk_room;
  assign s1_fire  = t1_valid && t1_ready;
  // t1 and packer accept together so the two streams stay beat-aligned.
  assign pk_push  = s1_valid_q && t1_ready;

  assign t1_data   = s1_t1_q;
  assign t1_idx    = t1_idx_q;
  assign range_err = range_err_q;
  assign busy      = state_q != StIdle;
  assign done      = state_q == StDone;

  abr_bit_packer #(
    .IN_W  (GrpW),
    .OUT_W (T0_OUT_W)
  ) u_packer (
    .clk        (clk),
    .clear      (clear),
    .push_valid (pk_push),
    .push_ready (pk_room),
    .push_data  (s1_t0_q),
    .pop_valid  (t0_valid),
    .pop_ready  (t0_ready),
    .pop_data   (t0_data),
    .fill       (pk_fill)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (num_poly == '0) ? StDone : StRun;
      StRun:   if (in_fire && (beat_cnt_q == total_beats_q - BcntW'(1))) state_d = StFlush;
      StFlush: if (!s1_valid_q && (pk_fill == '0)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= StIdle;
      s1_valid_q    <= 1'b0;
      s1_t1_q       <= '0;
      s1_t0_q       <= '0;
      beat_cnt_q    <= '0;
      total_beats_q <= '0;
      t1_idx_q      <= '0;
      range_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        beat_cnt_q    <= '0;
        total_beats_q <= BcntW'(num_poly) * BcntW'(Bpp);
        t1_idx_q      <= '0;
        range_err_q   <= 1'b0;
      end
      if (in_fire) begin
        beat_cnt_q <= beat_cnt_q + BcntW'(1);
        s1_valid_q <= 1'b1;
        s1_t1_q    <= beat_t1;
        s1_t0_q    <= beat_t0;
        if (|lane_oor) range_err_q <= 1'b1;
      end else if (s1_fire) begin
        s1_valid_q <= 1'b0;
      end
      if (s1_fire) t1_idx_q <= t1_idx_q + IdxW'(1);
    end
  end

endmodule

// File: doc/power2round_stream.md
# power2round_stream

Parametrised, back-pressured successor to the ML-DSA Power2Round datapath. It sits between the t-vector source stream and two sinks: the sk encoder, which takes packed t0 words, and the pk encoder, which takes t1 lanes. Lane count, D, output word width and polynomial count are generalised. New behaviour over the fixed design: valid/ready flow control on every port, runtime polynomial count, a t0 bit-packer of arbitrary width, and a sticky range-error flag.

## Interface
- NUM_LANES, 8, coefficients per input beat
- COEFF_W, 24, input coefficient field width (low 23 bits used)
- MLDSA_Q, 8380417, modulus
- MLDSA_D, 13, dropped bits
- MLDSA_N, 256, coefficients per polynomial
- MAX_POLY, 8, maximum polynomials per run
- T0_OUT_W, 64, packed t0 word width; elaboration error unless (MLDSA_N*MLDSA_D) % T0_OUT_W == 0 and MLDSA_N % NUM_LANES == 0
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- zeroize  in  1  synchronous clear, identical effect to reset
- start  in  1  one-cycle run request, honoured only in IDLE
- num_poly  in  $clog2(MAX_POLY+1)  polynomials this run, sampled on start; 0 → immediate DONE
- in_valid / in_ready  in/out  1  input handshake
- in_data  in  NUM_LANES*COEFF_W  lane i at bits [i*COEFF_W +: COEFF_W]
- t1_valid / t1_ready  out/in  1  t1 handshake
- t1_data  out  NUM_LANES*(23-MLDSA_D)  t1 lanes, same lane order
- t1_idx  out  $clog2(MAX_POLY*MLDSA_N/NUM_LANES)  beat index of t1_data within the run
- t0_valid / t0_ready  out/in  1  packed-t0 handshake
- t0_data  out  T0_OUT_W  packed t0 encodings, LSB-first, lane 0 first
- busy  out  1  state != IDLE
- range_err  out  1  sticky; set when any accepted coefficient ≥ MLDSA_Q; cleared on start
- done  out  1  one-cycle pulse at end of run

## Operation
- FSM: IDLE → RUN on start (num_poly ≠ 0); IDLE → DONE on start with num_poly == 0. RUN → FLUSH after the last input beat is accepted (num_poly*MLDSA_N/NUM_LANES beats). FLUSH → DONE when the stage is empty, the packer fill is 0, and no t1 beat is pending. DONE → IDLE unconditionally; done is high only in DONE.
- Per lane, with r = low 23 bits: r1 = (r + 2^(D-1) − 1) >> D; r0 = r − r1·2^D; t0 = 2^(D-1) − r0, which always fits in D bits. t1 = r1, 23−D bits, no modular correction.
- Stage register S1 holds t1 lanes and NUM_LANES·D t0 bits.
- Packer: accumulator of T0_OUT_W + NUM_LANES·D bits plus a fill counter. It accepts an S1 group when fill < T0_OUT_W. It emits the low T0_OUT_W bits when fill ≥ T0_OUT_W. Push and pop in the same cycle are legal: fill' = fill + push·NUM_LANES·D − pop·T0_OUT_W.
- Beats outside RUN are never accepted (in_ready = 0). A start during RUN, FLUSH or DONE is ignored.

## Timing
- Reset/zeroize: all outputs 0, FSM IDLE, counters/fill/S1/accumulator cleared, range_err cleared. Takes effect on the next edge, even mid-run; no partial output afterwards.
- Control equations:
  - in_ready = RUN & (!S1_valid | S1_fire)
  - t1_valid = S1_valid & (fill < T0_OUT_W)
  - S1_fire = t1_valid & t1_ready
  - t0_valid = (fill ≥ T0_OUT_W)
- t1_valid does not depend on t1_ready, and t0_valid does not depend on t0_ready.
- Latency: a beat accepted at edge n gives t1_valid at n+1 (with packer room). Its bits are in the accumulator at n+2. With defaults, the first t0_valid is at n+2.
- Full throughput (one beat per cycle) is sustained only while the sinks keep up. With defaults, t0 drains 64 b/cycle against 104 b/beat, so in_ready duty settles to ≈ 8/13.
- t1_idx increments on each S1_fire and clears on start.

## Structure
- Width constants T1_W = 23 − MLDSA_D and the FSM state enum go in abr_params_pkg.
- Sub-module abr_bit_packer: generic IN_W/OUT_W accumulator with the push/pop rules above, reusable by future encoders.
- Per-lane arithmetic is a combinational function in the package.

## Test plan
- Vector of lanes {0, 8191, 4096, 4097, 8380416, 1, 2, 3} → t1 = {0, 1, 0, 1, 1023, 0, 0, 0}; t0 = {4096, 4097, 0, 8191, 4096, 4095, 4094, 4093}; the first t0_data word equals the low 64 bits of the packed concatenation.
- num_poly = 8, random coefficients < Q, both sinks always ready → exactly 256 t1 beats and 416 t0 words, matching the reference model. done pulses once, then busy = 0.
- Random stalls on t0_ready/t1_ready (30%) → identical output streams to the stall-free run, no loss or duplication. t1_valid/t0_valid never drop without a handshake.
- Lane 3 = 8380417 in beat 5 → range_err rises after acceptance, stays high through DONE, and clears on the next start.
- num_poly = 0 → done exactly one cycle after start, no output traffic. A start issued during RUN → ignored.
- reset asserted mid-FLUSH with fill = 40 → next cycle: all outputs 0 and IDLE. A fresh run then produces a clean stream.
